// File: rtl/systolic_seq.sv
// systolic_seq: job sequencer for the NxN systolic array.
// Clears the array, drives skewed feeds, drains results, reports done.
module systolic_seq #(
  parameter int N    = 16,
  parameter int KMAX = 256,
  parameter int SW   = $clog2(N + 1),
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [SW-1:0]   size_m,
  input  logic [SW-1:0]   size_p,
  input  logic [KW-1:0]   size_k,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            array_clear,
  output logic            array_through,
  output logic [N-1:0]    left_en,
  output logic [N-1:0]    top_en,
  output logic [KW+SW:0]  feed_t,
  output logic            out_valid,
  output logic [SW-1:0]   out_row
);

  localparam int CW = KW + SW + 1;
  localparam logic [CW-1:0] NC = CW'(N);
  localparam logic [CW-1:0] KC = CW'(KMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] m_q, m_d;
  logic [SW-1:0] p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          clr_q, clr_d;
  logic          thr_q, thr_d;
  logic          ov_q, ov_d;
  logic [SW-1:0] row_q, row_d;
  logic [CW-1:0] last_t;
  logic          legal;

  // Final feed step L-1; only meaningful while sizes are latched.
  assign last_t = CW'(k_q) + CW'(m_q) + CW'(p_q) - CW'(3);

  assign legal = (size_m != '0) && (CW'(size_m) <= NC) &&
                 (size_p != '0) && (CW'(size_p) <= NC) &&
                 (size_k != '0) && (CW'(size_k) <= KC);

  // Next state, step counter, size latch and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_d     = p_q;
    k_d     = k_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          if (legal) begin
            m_d     = size_m;
            p_d     = size_p;
            k_d     = size_k;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (cnt_q == last_t) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == NC - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        m_d     = '0;
        p_d     = '0;
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      m_d     = '0;
      p_d     = '0;
      k_d     = '0;
    end
    busy_d = state_d != S_IDLE;
    clr_d  = state_d == S_CLEAR;
    thr_d  = state_d == S_DRAIN;
    done_d = state_d == S_DONE;
    ov_d   = thr_d && (cnt_d >= NC - CW'(m_d));
    row_d  = thr_d ? SW'(NC - CW'(1) - cnt_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      thr_q   <= 1'b0;
      ov_q    <= 1'b0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      thr_q   <= thr_d;
      ov_q    <= ov_d;
      row_q   <= row_d;
    end
  end

  // Skewed feed enables decoded from the step count and latched sizes.
  always_comb begin
    left_en = '0;
    top_en  = '0;
    feed_t  = '0;
    if (state_q == S_FEED) begin
      feed_t = cnt_q;
      for (int i = 0; i < N; i++) begin
        left_en[i] = (CW'(i) < CW'(m_q)) && (cnt_q >= CW'(i)) &&
                     (cnt_q < CW'(i) + CW'(k_q));
        top_en[i]  = (CW'(i) < CW'(p_q)) && (cnt_q >= CW'(i)) &&
                     (cnt_q < CW'(i) + CW'(k_q));
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign array_clear   = clr_q;
  assign array_through = thr_q;
  assign out_valid     = ov_q;
  assign out_row       = row_q;

endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: scoreboard bench for systolic_seq.
// Expected per-cycle outputs are queued at stimulus time, popped per cycle.
module tb_systolic_seq;

  localparam int N    = 4;
  localparam int KMAX = 16;
  localparam int SW   = $clog2(N + 1);
  localparam int KW   = $clog2(KMAX + 1);
  localparam int FW   = KW + SW + 1;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic          clr;
    logic          thr;
    logic [N-1:0]  le;
    logic [N-1:0]  te;
    logic [FW-1:0] ft;
    logic          ov;
    logic [SW-1:0] row;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [SW-1:0] size_m;
  logic [SW-1:0] size_p;
  logic [KW-1:0] size_k;
  logic          busy;
  logic          done;
  logic          err;
  logic          array_clear;
  logic          array_through;
  logic [N-1:0]  left_en;
  logic [N-1:0]  top_en;
  logic [FW-1:0] feed_t;
  logic          out_valid;
  logic [SW-1:0] out_row;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  systolic_seq #(.N(N), .KMAX(KMAX)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .size_m        (size_m),
    .size_p        (size_p),
    .size_k        (size_k),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .array_clear   (array_clear),
    .array_through (array_through),
    .left_en       (left_en),
    .top_en        (top_en),
    .feed_t        (feed_t),
    .out_valid     (out_valid),
    .out_row       (out_row)
  );

  always #5 clk = ~clk;

  function automatic exp_t obs();
    exp_t o;
    o = '{busy, done, err, array_clear, array_through,
          left_en, top_en, feed_t, out_valid, out_row};
    return o;
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("busy%0b done%0b err%0b clr%0b thr%0b le%b te%b t%0d ov%0b row%0d",
                     x.busy, x.done, x.err, x.clr, x.thr,
                     x.le, x.te, x.ft, x.ov, x.row);
  endfunction

  // Expected outputs for cycles 1..min(upto, L+N+2) after a start.
  task automatic push_job(input int m, input int p, input int k,
                          input int upto);
    int l;
    l = k + m + p - 2;
    for (int c = 1; c <= l + N + 2 && c <= upto; c++) begin
      exp_t e;
      e = '0;
      e.busy = 1'b1;
      if (c == 1) begin
        e.clr = 1'b1;
      end else if (c <= l + 1) begin
        int t;
        t = c - 2;
        e.ft = FW'(t);
        for (int i = 0; i < N; i++) begin
          e.le[i] = (i < m) && (t >= i) && (t - i < k);
          e.te[i] = (i < p) && (t >= i) && (t - i < k);
        end
      end else if (c <= l + N + 1) begin
        int d;
        d = c - l - 2;
        e.thr = 1'b1;
        e.ov  = (d >= N - m);
        e.row = SW'(N - 1 - d);
      end else begin
        e.done = 1'b1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    repeat (n) sb.push_back('0);
  endtask

  task automatic drive(input int m, input int p, input int k,
                       input logic s);
    size_m = SW'(m);
    size_p = SW'(p);
    size_k = KW'(k);
    start  = s;
  endtask

  task automatic test_reset();
    exp_t g, e;
    int   n;
    #12;
    g = obs();
    checks++;
    if (g !== exp_t'('0)) begin
      errors++;
      $display("FAIL reset_hold got %s need all zero", fmt(g));
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_idle(3);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      g = obs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_idle got %s need %s", fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_basic(input int m, input int p, input int k);
    exp_t g, e;
    int   n;
    drive(m, p, k, 1'b1);
    push_job(m, p, k, 1 << 20);
    push_idle(2);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = 1'b0;
      e = sb.pop_front();
      g = obs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL basic m%0d p%0d k%0d cyc%0d got %s need %s",
                 m, p, k, i + 1, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_illegal();
    exp_t g, e;
    int   n;
    int   tm[4] = '{0, 2, 2, 2};
    int   tp[4] = '{3, 5, 3, 3};
    int   tk[4] = '{2, 2, 0, 17};
    for (int s = 0; s < 4; s++) begin
      drive(tm[s], tp[s], tk[s], 1'b1);
      e = '0;
      e.err = 1'b1;
      sb.push_back(e);
      push_idle(2);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        if (i == 0) start = 1'b0;
        e = sb.pop_front();
        g = obs();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL illegal%0d cyc%0d got %s need %s",
                   s, i + 1, fmt(g), fmt(e));
        end
      end
    end
  endtask

  task automatic test_abort();
    exp_t g, e;
    int   n;
    drive(2, 3, 2, 1'b1);
    push_job(2, 3, 2, 4);
    push_idle(2);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      g = obs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL abort_feed cyc%0d got %s need %s",
                 i + 1, fmt(g), fmt(e));
      end
      if (i == 0) start = 1'b0;
      if (i == 3) abort = 1'b1;
      if (i == 4) abort = 1'b0;
    end
    drive(2, 3, 2, 1'b1);
    abort = 1'b1;
    push_idle(2);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        start = 1'b0;
        abort = 1'b0;
      end
      e = sb.pop_front();
      g = obs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL abort_start cyc%0d got %s need %s",
                 i + 1, fmt(g), fmt(e));
      end
    end
    test_basic(3, 1, 3);
  endtask

  task automatic test_full();
    exp_t g, e;
    int   n;
    int   maxft;
    int   done_cyc;
    maxft    = -1;
    done_cyc = -1;
    drive(N, N, KMAX, 1'b1);
    push_job(N, N, KMAX, 1 << 20);
    push_idle(1);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = 1'b0;
      e = sb.pop_front();
      g = obs();
      if (int'(g.ft) > maxft) maxft = int'(g.ft);
      if (g.done === 1'b1 && done_cyc < 0) done_cyc = i + 1;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL full cyc%0d got %s need %s",
                 i + 1, fmt(g), fmt(e));
      end
    end
    checks++;
    if (maxft != KMAX + 5) begin
      errors++;
      $display("FAIL full_max_t got %0d need %0d", maxft, KMAX + 5);
    end
    checks++;
    if (done_cyc != KMAX + 12) begin
      errors++;
      $display("FAIL full_latency got %0d need %0d", done_cyc, KMAX + 12);
    end
  endtask

  task automatic test_reset_drain();
    exp_t g, e;
    int   n;
    drive(4, 2, 1, 1'b1);
    push_job(4, 2, 1, 7);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = 1'b0;
      e = sb.pop_front();
      g = obs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rst_pre cyc%0d got %s need %s",
                 i + 1, fmt(g), fmt(e));
      end
    end
    #3;
    reset_n = 1'b0;
    #1;
    g = obs();
    checks++;
    if (g !== exp_t'('0)) begin
      errors++;
      $display("FAIL rst_async got %s need all zero", fmt(g));
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_idle(3);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      g = obs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rst_after cyc%0d got %s need %s",
                 i + 1, fmt(g), fmt(e));
      end
    end
    test_basic(2, 2, 3);
  endtask

  task automatic test_back_to_back();
    exp_t g, e;
    int   n;
    int   l;
    l = 3 + 2 + 2 - 2;
    drive(2, 2, 3, 1'b1);
    push_job(2, 2, 3, 1 << 20);
    push_idle(1);
    push_job(2, 2, 3, 1 << 20);
    push_idle(2);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == l + N + 3) start = 1'b0;
      e = sb.pop_front();
      g = obs();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b cyc%0d got %s need %s",
                 i + 1, fmt(g), fmt(e));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    abort   = 1'b0;
    drive(0, 0, 0, 1'b0);
    test_reset();
    test_basic(2, 3, 2);
    test_illegal();
    test_abort();
    test_full();
    test_reset_drain();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d need 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
